// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the Pong game-sequencing controller: state
// encodings, default parameters and the BCD digit helper.
package pong_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  localparam int unsigned NUM_BALLS_DEF    = 3;
  localparam int unsigned TIMER_FRAMES_DEF = 120;
  localparam int unsigned TIMER_W          = 7;
  localparam int unsigned BALLS_W          = 2;

  // Advance one BCD digit; the caller handles the carry on 9 -> 0.
  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/pong_score_bcd.sv
// Two-digit BCD score counter, 00..99 with wrap. Clear beats increment.
import pong_game_ctrl_pkg::*;

module pong_score_bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig0_q, dig0_d;

  // Next score: clear, else BCD increment with tens carry and 99 -> 00 wrap.
  always_comb begin
    dig1_d = dig1_q;
    dig0_d = dig0_q;
    if (clr) begin
      dig1_d = 4'd0;
      dig0_d = 4'd0;
    end else if (inc) begin
      dig0_d = bcd_digit_inc(dig0_q);
      if (dig0_q == 4'd9) dig1_d = bcd_digit_inc(dig1_q);
    end
  end

  // Score registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig1_q <= 4'd0;
      dig0_q <= 4'd0;
    end else begin
      dig1_q <= dig1_d;
      dig0_q <= dig0_d;
    end
  end

  assign dig1 = dig1_q;
  assign dig0 = dig0_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: NEWGAME / PLAY / NEWBALL / OVER FSM, frame-based
// delay timer, balls-remaining counter and the BCD score. All outputs
// are decodes of registered state.
import pong_game_ctrl_pkg::*;

module pong_game_ctrl #(
  parameter int unsigned NUM_BALLS    = NUM_BALLS_DEF,
  parameter int unsigned TIMER_FRAMES = TIMER_FRAMES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         refr_tick,
  input  logic [1:0]   btn,
  input  logic         hit,
  input  logic         miss,
  output logic         gra_still,
  output logic         show_rules,
  output logic         show_over,
  output logic [7:0]   score,
  output logic [1:0]   balls_left
);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMER_FRAMES);
  localparam logic [BALLS_W-1:0] BALLS_INIT = BALLS_W'(NUM_BALLS);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [BALLS_W-1:0]   balls_q, balls_d;
  logic                 score_clr, score_inc;
  logic                 pressed, timer_done, play_miss;
  logic [3:0]           dig1, dig0;

  assign pressed    = |btn;
  assign timer_done = (timer_q == '0);
  assign play_miss  = (state_q == ST_PLAY) && miss;

  // Next state, balls count and score controls.
  always_comb begin
    state_d   = state_q;
    balls_d   = balls_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      ST_NEWGAME: begin
        if (pressed) begin
          state_d   = ST_PLAY;
          score_clr = 1'b1;
          if (balls_q != '0) balls_d = balls_q - 1'b1;
        end
      end
      ST_PLAY: begin
        // A miss swallows any coincident hit.
        if (miss) begin
          if (balls_q == '0) begin
            state_d = ST_OVER;
          end else begin
            balls_d = balls_q - 1'b1;
            state_d = ST_NEWBALL;
          end
        end else if (hit) begin
          score_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (timer_done && pressed) state_d = ST_PLAY;
      end
      ST_OVER: begin
        // Score is left alone so it stays on screen until the next start.
        if (timer_done) begin
          state_d = ST_NEWGAME;
          balls_d = BALLS_INIT;
        end
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  // Frame timer: a miss reloads it (even on a tick), otherwise count down to zero.
  always_comb begin
    timer_d = timer_q;
    if (play_miss)                     timer_d = TIMER_LOAD;
    else if (refr_tick && !timer_done) timer_d = timer_q - 1'b1;
  end

  // State, timer and balls registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_NEWGAME;
      timer_q <= '0;
      balls_q <= BALLS_INIT;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      balls_q <= balls_d;
    end
  end

  pong_score_bcd u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .dig1  (dig1),
    .dig0  (dig0)
  );

  assign gra_still  = (state_q != ST_PLAY);
  assign show_rules = (state_q == ST_NEWGAME);
  assign show_over  = (state_q == ST_OVER);
  assign score      = {dig1, dig0};
  assign balls_left = balls_q;

endmodule
